// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer driving a 1-bit ALU slice LSB first, feeding carry back each clock
module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             sl_a,
  output logic             sl_b,
  output logic [3:0]       sl_s,
  output logic             sl_m,
  output logic             sl_cin,
  input  logic             sl_do,
  input  logic             sl_co
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic [3:0] s_q;
  logic m_q, carry_q, carry_nx, last, in_shift;
  logic [CNT_W-1:0] bit_cnt;
  assign in_shift = state == SHIFT;
  assign last = bit_cnt == CNT_W'(WIDTH - 1);
  assign acc_nx = {sl_do, acc[WIDTH-1:1]};
  // logic mode freezes the carry chain so the latched cin is reported as cout
  assign carry_nx = m_q ? carry_q : sl_co;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_sh    <= a;
        b_sh    <= b;
        s_q     <= s;
        m_q     <= m;
        carry_q <= cin;
        bit_cnt <= '0;
        acc     <= '0;
      end else if (in_shift) begin
        acc     <= acc_nx;
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        carry_q <= carry_nx;
        bit_cnt <= bit_cnt + 1'b1;
        if (last) begin
          result <= acc_nx;
          cout   <= carry_nx;
        end
      end
    end
  end
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    sl_a     = 1'b0;
    sl_b     = 1'b0;
    sl_s     = '0;
    sl_m     = 1'b0;
    sl_cin   = 1'b0;
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy     = state != IDLE;
    done     = state == DONE;
    sl_a     = in_shift & a_sh[0];
    sl_b     = in_shift & b_sh[0];
    sl_s     = in_shift ? s_q : 4'b0;
    sl_m     = in_shift & m_q;
    sl_cin   = in_shift & carry_q;
  end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: word-level reference model plus directed and random ops against alu_serial_ctrl
module tb_alu_serial_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, m = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0, result;
  logic [3:0] s = '0, sl_s;
  logic busy, done, cout, sl_a, sl_b, sl_m, sl_cin, sl_do, sl_co;
  int n_cmp = 0, n_bad = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .sl_a(sl_a), .sl_b(sl_b), .sl_s(sl_s), .sl_m(sl_m), .sl_cin(sl_cin),
    .sl_do(sl_do), .sl_co(sl_co)
  );

  // slice: M=0 full adder, M=1 xor with no carry
  assign sl_do = sl_m ? (sl_a ^ sl_b) : (sl_a ^ sl_b ^ sl_cin);
  assign sl_co = sl_m ? 1'b0 : ((sl_a & sl_b) | (sl_a & sl_cin) | (sl_b & sl_cin));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // word-level model: an op is accepted at edge acc_e, done shows after edge acc_e+W
  int e = 0, acc_e = 0;
  bit act = 0;
  logic [W-1:0] la, lb, m_res = '0, p_res;
  logic [3:0] ls;
  logic lm, lc, m_cout = 1'b0, p_cout;
  always @(posedge clk) begin
    e++;
    if (rst) begin
      act = 0; m_res = '0; m_cout = 1'b0;
    end else if (act) begin
      if (e == acc_e + W + 1) act = 0;
      else if (e == acc_e + W) begin m_res = p_res; m_cout = p_cout; end
    end else if (start) begin
      act = 1; acc_e = e; la = a; lb = b; ls = s; lm = m; lc = cin;
      if (m) begin p_res = a ^ b; p_cout = cin; end
      else {p_cout, p_res} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    end
  end

  always @(negedge clk) if (e > 0) begin
    int i;
    bit sh;
    int unsigned msk, lo;
    i = e - acc_e;
    sh = act && i < W;
    check("busy", busy, act);
    check("done", done, act && i == W);
    check("result", result, m_res);
    check("cout", cout, m_cout);
    if (sh) begin
      msk = (32'd1 << i) - 1;
      lo = (la & msk) + (lb & msk) + lc;
      check("sl_a", sl_a, la[i]);
      check("sl_b", sl_b, lb[i]);
      check("sl_s", sl_s, ls);
      check("sl_m", sl_m, lm);
      check("sl_cin", sl_cin, lm ? lc : lo[i]);
    end else
      check("sl_idle", {sl_a, sl_b, sl_s, sl_m, sl_cin}, 0);
  end

  task automatic issue(input logic [7:0] ta, tb, input logic [3:0] ts, input logic tm, tc);
    @(posedge clk); #1;
    a = ta; b = tb; s = ts; m = tm; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int j = 0; j < cycles; j++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  task automatic op(input string nm, input logic [7:0] ta, tb, input logic [3:0] ts,
                    input logic tm, tc, input logic [7:0] er, input logic ec);
    int n;
    issue(ta, tb, ts, tm, tc);
    wait_done(n);
    check({nm, "_lat"}, n, W);
    check({nm, "_res"}, result, er);
    check({nm, "_cout"}, cout, ec);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    check("rst_cout", cout, 0);
    check("rst_sl", {sl_a, sl_b, sl_s, sl_m, sl_cin}, 0);
    rst = 1'b0;
    op("add", 8'h5A, 8'h27, 4'b1001, 1'b0, 1'b0, 8'h81, 1'b0);
    op("cy_out", 8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0, 8'h00, 1'b1);
    op("cy_in", 8'h7F, 8'h00, 4'b1001, 1'b0, 1'b1, 8'h80, 1'b0);
    op("logic", 8'hF0, 8'h3C, 4'b0110, 1'b1, 1'b1, 8'hCC, 1'b1);
    // busy guard: re-pulse start with new operands in SHIFT cycle 3
    issue(8'h12, 8'h34, 4'b1001, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hEE; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    count_done(12, n);
    check("guard_dones", n, 1);
    check("guard_res", result, 8'h46);
    // abort in SHIFT cycle 4
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    issue(8'h5A, 8'h27, 4'b1001, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_res", result, 0);
    count_done(12, n);
    check("abort_dones", n, 0);
    op("post_abort", 8'h80, 8'h80, 4'b1001, 1'b0, 1'b1, 8'h01, 1'b1);
    for (int j = 0; j < 1500; j++) begin
      @(posedge clk); #1;
      start = ($urandom % 4) == 0;
      a = W'($urandom);
      b = W'($urandom);
      m = $urandom % 2;
      s = m ? 4'b0110 : 4'b1001;
      cin = $urandom % 2;
      rst = ($urandom % 150) == 0;
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
